// File: rtl/pc_flags_sequencer.sv
// pc_flags_sequencer: program counter, Z/N flags and halt detection for the
// single-cycle control path. Branch decisions use the flags latched by an
// earlier instruction, so a compare followed by a conditional jump needs no
// bubble.
// Optional build macro: PC_SEQ_RETIRE_COUNT_EN enables the saturating
// retired-instruction counter; without it `retired` is tied to zero.
module pc_flags_sequencer #(
    parameter int                  PC_WIDTH   = 8,
    parameter int                  DATA_WIDTH = 16,
    parameter logic [PC_WIDTH-1:0] RESET_PC   = '0
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  enable,
    input  logic                  flags_write,
    input  logic                  is_jz,
    input  logic                  is_jnz,
    input  logic                  is_jg,
    input  logic                  is_jl,
    input  logic                  is_jump,
    input  logic [DATA_WIDTH-1:0] alu_result,
    input  logic [PC_WIDTH-1:0]   jump_target,
    output logic [PC_WIDTH-1:0]   pc,
    output logic                  flag_z,
    output logic                  flag_n,
    output logic                  branch_taken,
    output logic                  halted,
    output logic [15:0]           retired
);

    typedef enum logic [0:0] {
        ST_RUN    = 1'b0,
        ST_HALTED = 1'b1
    } state_t;

    state_t                state_q, state_d;
    logic [PC_WIDTH-1:0]   pc_q, pc_d;
    logic                  flag_z_q, flag_z_d;
    logic                  flag_n_q, flag_n_d;
    logic                  cond_sel;
    logic                  advance;
    logic                  taken;
    logic                  self_branch;
    logic                  alu_zero;
    logic                  alu_neg;

    assign alu_zero = (alu_result == '0);
    assign alu_neg  = alu_result[DATA_WIDTH-1];

    // Select the condition of the highest-priority strobe against the stored flags.
    always_comb begin
        cond_sel = 1'b0;
        if (is_jump) begin
            cond_sel = 1'b1;
        end else if (is_jz) begin
            cond_sel = flag_z_q;
        end else if (is_jnz) begin
            cond_sel = !flag_z_q;
        end else if (is_jg) begin
            cond_sel = !flag_z_q && !flag_n_q;
        end else if (is_jl) begin
            cond_sel = flag_n_q;
        end
    end

    // An instruction only takes effect when enabled and not yet halted.
    assign advance     = enable && (state_q == ST_RUN);
    assign taken       = cond_sel && advance;
    assign self_branch = taken && (jump_target == pc_q);

    // Next-state logic: PC redirect/increment, flag latch, halt entry.
    always_comb begin
        state_d  = state_q;
        pc_d     = pc_q;
        flag_z_d = flag_z_q;
        flag_n_d = flag_n_q;
        case (state_q)
            ST_RUN: begin
                if (advance) begin
                    if (self_branch) begin
                        // The self-jump idiom parks the PC where it is.
                        state_d = ST_HALTED;
                        pc_d    = pc_q;
                    end else if (taken) begin
                        pc_d = jump_target;
                    end else begin
                        pc_d = pc_q + PC_WIDTH'(1);
                    end
                    // New flags land at the same edge the branch used the old ones.
                    if (flags_write) begin
                        flag_z_d = alu_zero;
                        flag_n_d = alu_neg;
                    end
                end
            end
            ST_HALTED: begin
                state_d = ST_HALTED;
            end
            default: begin
                state_d = ST_RUN;
            end
        endcase
    end

    // State, PC and flag registers; reset takes effect without a clock edge.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= ST_RUN;
            pc_q     <= RESET_PC;
            flag_z_q <= 1'b0;
            flag_n_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            pc_q     <= pc_d;
            flag_z_q <= flag_z_d;
            flag_n_q <= flag_n_d;
        end
    end

`ifdef PC_SEQ_RETIRE_COUNT_EN
    logic [15:0] retired_q, retired_d;

    // Count every enabled instruction in RUN, holding at all-ones.
    always_comb begin
        retired_d = retired_q;
        if (advance && (retired_q != 16'hFFFF)) begin
            retired_d = retired_q + 16'd1;
        end
    end

    // Retired-instruction counter register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            retired_q <= 16'h0000;
        end else begin
            retired_q <= retired_d;
        end
    end

    assign retired = retired_q;
`else
    assign retired = 16'h0000;
`endif

    assign pc           = pc_q;
    assign flag_z       = flag_z_q;
    assign flag_n       = flag_n_q;
    assign halted       = (state_q == ST_HALTED);
    assign branch_taken = taken;

endmodule

// File: tb/tb_pc_flags_sequencer.sv
// Scoreboard bench for pc_flags_sequencer: each stimulus cycle pushes the
// hand-computed state expected to be visible in that cycle; a monitor late in
// the low clock phase pops and compares.
module tb_pc_flags_sequencer;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        enable = 1'b0;
    logic        flags_write = 1'b0;
    logic        is_jz = 1'b0, is_jnz = 1'b0, is_jg = 1'b0, is_jl = 1'b0, is_jump = 1'b0;
    logic [15:0] alu_result = '0;
    logic [7:0]  jump_target = '0;
    logic [7:0]  pc;
    logic        flag_z, flag_n, branch_taken, halted;
    logic [15:0] retired;

    int checks = 0;
    int errors = 0;

    typedef struct {
        string       name;
        logic        bt;
        logic [7:0]  pc;
        logic        z;
        logic        n;
        logic        h;
        logic [15:0] ret;
    } exp_t;

    exp_t sb_q[$];
    int   ret_cnt = 0;

    pc_flags_sequencer #(.PC_WIDTH(8), .DATA_WIDTH(16), .RESET_PC(8'h00)) dut (
        .clk(clk), .reset(reset), .enable(enable), .flags_write(flags_write),
        .is_jz(is_jz), .is_jnz(is_jnz), .is_jg(is_jg), .is_jl(is_jl), .is_jump(is_jump),
        .alu_result(alu_result), .jump_target(jump_target),
        .pc(pc), .flag_z(flag_z), .flag_n(flag_n), .branch_taken(branch_taken),
        .halted(halted), .retired(retired)
    );

    always #5 clk = ~clk;

    function automatic logic [15:0] ret_exp(input int n);
`ifdef PC_SEQ_RETIRE_COUNT_EN
        return 16'(n);
`else
        return 16'h0000 + 16'(n * 0);
`endif
    endfunction

    // strobes packed as {jump, jz, jnz, jg, jl}
    task automatic step(input string name, input logic rst, input logic mid_rst,
                        input logic en, input logic fw, input logic [4:0] strb,
                        input logic [15:0] alu, input logic [7:0] tgt,
                        input logic e_bt, input logic [7:0] e_pc, input logic e_z,
                        input logic e_n, input logic e_h, input bit adv);
        exp_t e;
        @(negedge clk);
        reset       = rst;
        enable      = en;
        flags_write = fw;
        {is_jump, is_jz, is_jnz, is_jg, is_jl} = strb;
        alu_result  = alu;
        jump_target = tgt;
        if (rst || mid_rst) ret_cnt = 0;
        e.name = name; e.bt = e_bt; e.pc = e_pc; e.z = e_z; e.n = e_n; e.h = e_h;
        e.ret = ret_exp(ret_cnt);
        sb_q.push_back(e);
        if (adv) ret_cnt++;
        if (mid_rst) begin
            #1 reset = 1'b1;
        end
    endtask

    task automatic chk1(input string name, input string fld, input logic [15:0] act,
                        input logic [15:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s.%s actual=%h required=%h", name, fld, act, req);
        end
    endtask

    // Monitor: sample late in the low phase, after inputs settle, before the edge.
    always @(negedge clk) begin
        #4;
        if (sb_q.size() > 0) begin
            exp_t e;
            e = sb_q.pop_front();
            chk1(e.name, "branch_taken", {15'd0, branch_taken}, {15'd0, e.bt});
            chk1(e.name, "pc", {8'd0, pc}, {8'd0, e.pc});
            chk1(e.name, "flag_z", {15'd0, flag_z}, {15'd0, e.z});
            chk1(e.name, "flag_n", {15'd0, flag_n}, {15'd0, e.n});
            chk1(e.name, "halted", {15'd0, halted}, {15'd0, e.h});
            chk1(e.name, "retired", retired, e.ret);
            $display("txn %-10s pc=%h z=%b n=%b bt=%b h=%b ret=%0d", e.name, pc, flag_z,
                     flag_n, branch_taken, halted, retired);
        end
    end

    initial begin
        // Power-on reset.
        step("reset", 1, 0, 0, 0, 5'b00000, 16'h0, 8'h00, 0, 8'h00, 0, 0, 0, 0);
        // Run to pc 0x23, setting Z at pc 0x21.
        for (int i = 0; i < 35; i++) begin
            step("run", 0, 0, 1, (i == 33), 5'b00000, 16'h0000, 8'h00,
                 0, 8'(i), (i >= 34), 0, 0, 1);
        end
        // Asynchronous reset between edges while pc shows 0x23.
        step("mid_rst", 0, 1, 1, 0, 5'b00000, 16'h0, 8'h00, 0, 8'h00, 0, 0, 0, 0);
        // 300 sequential fetches, wrapping 0xFF -> 0x00.
        for (int i = 0; i < 300; i++) begin
            step("seq", 0, 0, 1, 0, 5'b00000, 16'h0, 8'h00, 0, 8'(i % 256), 0, 0, 0, 1);
        end
        // cmp then jz back-to-back.
        step("cmp", 0, 0, 1, 1, 5'b00000, 16'h0000, 8'h00, 0, 8'h2C, 0, 0, 0, 1);
        step("jz", 0, 0, 1, 0, 5'b01000, 16'h0, 8'h40, 1, 8'h2D, 1, 0, 0, 1);
        // Negative result, then jg (not taken) and jl (taken).
        step("wr_neg", 0, 0, 1, 1, 5'b00000, 16'h8001, 8'h00, 0, 8'h40, 1, 0, 0, 1);
        step("jg_nt", 0, 0, 1, 0, 5'b00010, 16'h0, 8'h10, 0, 8'h41, 0, 1, 0, 1);
        step("jl_t", 0, 0, 1, 0, 5'b00001, 16'h0, 8'h20, 1, 8'h42, 0, 1, 0, 1);
        // Flag write with jz: branch sees old Z=0, new Z=1 latches.
        step("fw_jz", 0, 0, 1, 1, 5'b01000, 16'h0000, 8'h50, 0, 8'h20, 0, 1, 0, 1);
        step("jnz_nt", 0, 0, 1, 0, 5'b00100, 16'h0, 8'h60, 0, 8'h21, 1, 0, 0, 1);
        step("wr_pos", 0, 0, 1, 1, 5'b00000, 16'h0005, 8'h00, 0, 8'h22, 1, 0, 0, 1);
        // Priority: jump beats jz with Z=0.
        step("prio", 0, 0, 1, 0, 5'b11000, 16'h0, 8'h30, 1, 8'h23, 0, 0, 0, 1);
        // Disabled cycles hold state.
        step("dis_jmp", 0, 0, 0, 1, 5'b10000, 16'h0000, 8'h77, 0, 8'h30, 0, 0, 0, 0);
        step("dis", 0, 0, 0, 0, 5'b00000, 16'h0, 8'h00, 0, 8'h30, 0, 0, 0, 0);
        step("jg_t", 0, 0, 1, 0, 5'b00010, 16'h0, 8'h05, 1, 8'h30, 0, 0, 0, 1);
        // Self-jump at 0x05 halts; halting instruction retires.
        step("halt", 0, 0, 1, 0, 5'b10000, 16'h0, 8'h05, 1, 8'h05, 0, 0, 0, 1);
        for (int i = 0; i < 10; i++) begin
            step("halted", 0, 0, 1, 1, 5'b10000, 16'h0000, 8'h99, 0, 8'h05, 0, 0, 1, 0);
        end
        // Only reset leaves HALTED.
        step("rst_halt", 1, 0, 0, 0, 5'b00000, 16'h0, 8'h00, 0, 8'h00, 0, 0, 0, 0);
        step("restart", 0, 0, 1, 0, 5'b00000, 16'h0, 8'h00, 0, 8'h00, 0, 0, 0, 1);
        step("post", 0, 0, 0, 0, 5'b00000, 16'h0, 8'h00, 0, 8'h01, 0, 0, 0, 0);

        for (int i = 0; i < 10 && sb_q.size() > 0; i++) @(negedge clk);
        #6;
        if (sb_q.size() > 0) begin
            errors++;
            $display("FAIL drain pending=%0d required=0", sb_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
